// File: rtl/wb_stream_pkg.sv
// Shared types and constants for the Wishbone stream writer: FSM state encoding
// and the Wishbone cycle-type / burst-type codes.
package wb_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_stream_writer_if.sv
// Wishbone master bus bundle; signal names keep the _o/_i suffixes as seen from the master.
interface wb_stream_writer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_we_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic [2:0]      wb_cti_o;
    logic [1:0]      wb_bte_o;
    logic            wb_ack_i;
    logic            wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        input  wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        output wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_stream_fifo.sv
// First-word-fall-through synchronous FIFO, depth 2**AW; push and pop may share a cycle.
module wb_stream_fifo #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible through count_q.
    always_ff @(posedge wb_clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

endmodule

// File: rtl/wb_stream_writer.sv
// Collects stream words in a FIFO and writes them to memory as incrementing Wishbone bursts.
//   state    | meaning
//   ST_IDLE  | waiting for a rising edge on enable
//   ST_FILL  | accepting stream words until the next burst is fully buffered
//   ST_BURST | driving the burst, one beat per ack
//   ST_DONE  | one-cycle completion, busy low, results held
module wb_stream_writer
    import wb_stream_pkg::*;
#(
    parameter int WB_AW   = 32,
    parameter int WB_DW   = 32,
    parameter int FIFO_AW = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             enable,
    input  logic [WB_AW-1:0] start_adr,
    input  logic [WB_AW-1:0] buf_size,
    input  logic [WB_AW-1:0] burst_size,
    output logic             busy,
    output logic [WB_DW-1:0] tx_cnt,
    output logic             err,
    input  logic [WB_DW-1:0] stream_data,
    input  logic             stream_valid,
    output logic             stream_ready,
    wb_stream_writer_if.master wb
);
    localparam logic [WB_AW-1:0] DEPTH = WB_AW'(2 ** FIFO_AW);

    state_e           state_q, state_d;
    logic             enable_q;
    logic             err_q, err_d;
    logic [WB_AW-1:0] adr_q, adr_d;
    logic [WB_AW-1:0] size_q, size_d;
    logic [WB_AW-1:0] burst_q, burst_d;
    logic [WB_AW-1:0] tx_cnt_q, tx_cnt_d;
    logic [WB_AW-1:0] acc_q, acc_d;
    logic [WB_AW-1:0] beats_q, beats_d;

    logic             start_edge, beat_ack, beat_err;
    logic [WB_AW-1:0] burst_eff, remaining, burst_len;
    logic             fifo_push, fifo_full, fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic [WB_DW-1:0] fifo_dout;

    assign start_edge = enable && !enable_q;
    assign burst_eff  = (burst_size == '0) ? WB_AW'(1) :
                        (burst_size > DEPTH) ? DEPTH : burst_size;
    assign remaining  = size_q - tx_cnt_q;
    assign burst_len  = (burst_q < remaining) ? burst_q : remaining;
    assign beat_err   = (state_q == ST_BURST) && wb.wb_err_i;
    assign beat_ack   = (state_q == ST_BURST) && wb.wb_ack_i && !wb.wb_err_i;
    assign fifo_push  = stream_valid && stream_ready;

    wb_stream_fifo #(
        .DW (WB_DW),
        .AW (FIFO_AW)
    ) u_fifo (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .flush     (beat_err),
        .push      (fifo_push),
        .din       (stream_data),
        .pop       (beat_ack),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q  <= ST_IDLE;
            enable_q <= 1'b0;
            err_q    <= 1'b0;
            adr_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            tx_cnt_q <= '0;
            acc_q    <= '0;
            beats_q  <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable;
            err_q    <= err_d;
            adr_q    <= adr_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            tx_cnt_q <= tx_cnt_d;
            acc_q    <= acc_d;
            beats_q  <= beats_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        adr_d    = adr_q;
        size_d   = size_q;
        burst_d  = burst_q;
        tx_cnt_d = tx_cnt_q;
        acc_d    = acc_q + WB_AW'(fifo_push);
        beats_d  = beats_q;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d  = ST_FILL;
                    adr_d    = start_adr;
                    size_d   = buf_size;
                    burst_d  = burst_eff;
                    tx_cnt_d = '0;
                    err_d    = 1'b0;
                    acc_d    = '0;
                end
            end
            ST_FILL: begin
                if (remaining == '0) begin
                    state_d = ST_DONE;
                end else if (WB_AW'(fifo_count) >= burst_len) begin
                    state_d = ST_BURST;
                    beats_d = burst_len;
                end
            end
            ST_BURST: begin
                if (beat_err) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (beat_ack) begin
                    adr_d    = adr_q + WB_AW'(4);
                    tx_cnt_d = tx_cnt_q + WB_AW'(1);
                    beats_d  = beats_q - WB_AW'(1);
                    if (beats_q == WB_AW'(1)) begin
                        state_d = (tx_cnt_d < size_q) ? ST_FILL : ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == ST_FILL) || (state_q == ST_BURST);
        stream_ready = busy && !fifo_full && (acc_q < size_q);
        tx_cnt       = WB_DW'(tx_cnt_q);
        err          = err_q;
        wb.wb_adr_o  = adr_q;
        wb.wb_dat_o  = '0;
        wb.wb_sel_o  = '0;
        wb.wb_we_o   = 1'b0;
        wb.wb_cyc_o  = 1'b0;
        wb.wb_stb_o  = 1'b0;
        wb.wb_cti_o  = CTI_CLASSIC;
        wb.wb_bte_o  = BTE_LINEAR;
        if (state_q == ST_BURST) begin
            wb.wb_cyc_o = 1'b1;
            wb.wb_stb_o = 1'b1;
            wb.wb_we_o  = 1'b1;
            wb.wb_sel_o = '1;
            wb.wb_dat_o = fifo_empty ? '0 : fifo_dout;
            wb.wb_cti_o = (beats_q == WB_AW'(1)) ? CTI_EOB : CTI_INC;
        end
    end

endmodule

// File: tb/tb_wb_stream_writer.sv
// Directed and randomised transfers against a beat-list reference model; a background
// slave acks randomly and checks every beat, while a stream source feeds random words.
module tb_wb_stream_writer;
    import wb_stream_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] start_adr = '0, buf_size = '0, burst_size = '0;
    logic        busy, err, stream_ready;
    logic [31:0] tx_cnt;
    logic [31:0] stream_data = '0;
    logic        stream_valid = 1'b0;

    always #5 clk = ~clk;

    wb_stream_writer_if #(.AW(32), .DW(32)) wb ();

    wb_stream_writer #(.WB_AW(32), .WB_DW(32), .FIFO_AW(4)) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .enable       (enable),
        .start_adr    (start_adr),
        .buf_size     (buf_size),
        .burst_size   (burst_size),
        .busy         (busy),
        .tx_cnt       (tx_cnt),
        .err          (err),
        .stream_data  (stream_data),
        .stream_valid (stream_valid),
        .stream_ready (stream_ready),
        .wb           (wb.master)
    );

    int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: beat i goes to start+4i and carries the i-th stream word; bursts
    // are consecutive chunks of the clamped burst size, the last beat of each being EOB.
    logic [31:0] words   [64];
    logic [31:0] exp_adr [64];
    logic [2:0]  exp_cti [64];
    int          n_exp = 0, beat = 0, err_beat = -1, widx = 0;
    bit          mon_on = 0, drv_on = 0, expect_drop = 0, acc_pending = 0;

    task automatic build_model(input logic [31:0] st, input logic [31:0] sz, input logic [31:0] bs);
        int eff;
        eff = (bs == 0) ? 1 : ((bs > 16) ? 16 : int'(bs));
        n_exp = int'(sz);
        for (int i = 0; i < 64; i++) begin
            words[i]   = $urandom;
            exp_adr[i] = st + 32'(4 * i);
            exp_cti[i] = (((i + 1) % eff) == 0 || i == n_exp - 1) ? 3'b111 : 3'b010;
        end
    endtask

    always @(negedge clk) begin
        if (drv_on) begin
            if (acc_pending) widx++;
            stream_valid = ($urandom_range(0, 3) != 0);
            stream_data  = words[widx % 64];
            acc_pending  = stream_valid && stream_ready;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (expect_drop) begin
                check("cyc_drop", wb.wb_cyc_o, 0);
                expect_drop = 0;
            end
            wb.wb_ack_i = 1'b0;
            wb.wb_err_i = 1'b0;
            if (wb.wb_cyc_o && wb.wb_stb_o) begin
                if (beat == err_beat) begin
                    check("err_beat_adr", wb.wb_adr_o, exp_adr[beat]);
                    wb.wb_err_i = 1'b1;
                    err_beat    = -1;
                    expect_drop = 1;
                end else if ($urandom_range(0, 3) != 0) begin
                    wb.wb_ack_i = 1'b1;
                    if (beat < n_exp && beat < 64) begin
                        check("adr", wb.wb_adr_o, exp_adr[beat]);
                        check("dat", wb.wb_dat_o, words[beat]);
                        check("cti", wb.wb_cti_o, exp_cti[beat]);
                        check("we_sel_bte", {wb.wb_we_o, wb.wb_sel_o, wb.wb_bte_o}, 7'b1_1111_00);
                        if (exp_cti[beat] == 3'b111) expect_drop = 1;
                    end else begin
                        check("extra_beat", beat, n_exp - 1);
                    end
                    beat++;
                end
            end
        end
    end

    task automatic run_xfer(input logic [31:0] st, input logic [31:0] sz, input logic [31:0] bs,
                            input int eb);
        bit          done;
        logic [31:0] exp_tx;
        exp_tx = (eb >= 0) ? 32'(eb) : sz;
        build_model(st, sz, bs);
        beat = 0; expect_drop = 0; err_beat = eb; widx = 0; acc_pending = 0;
        start_adr = st; buf_size = sz; burst_size = bs;
        mon_on = 1; drv_on = 1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        start_adr = $urandom; buf_size = $urandom; burst_size = $urandom;
        check("busy_rise", busy, 1);
        done = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c == 8 && busy) enable = 1'b1;
            if (c == 9) enable = 1'b0;
            if (!busy) begin
                done = 1;
                break;
            end
        end
        check("done_timeout", done, 1);
        drv_on = 0;
        stream_valid = 1'b0;
        check("tx_cnt", tx_cnt, exp_tx);
        check("err", err, (eb >= 0));
        check("beats", beat, exp_tx);
        repeat (3) @(negedge clk);
        check("tx_cnt_hold", tx_cnt, exp_tx);
        check("busy_idle", busy, 0);
        mon_on = 0;
        wb.wb_ack_i = 1'b0;
        wb.wb_err_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        wb.wb_ack_i = 1'b0;
        wb.wb_err_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_tx_cnt", tx_cnt, 0);
        check("rst_ready", stream_ready, 0);
        check("rst_cyc_stb_we", {wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o}, 0);
        check("rst_adr", wb.wb_adr_o, 0);
        check("rst_sel_cti_bte", {wb.wb_sel_o, wb.wb_cti_o, wb.wb_bte_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_xfer(32'h0000_1000, 8, 4, -1);
        run_xfer(32'h0000_1000, 5, 4, -1);
        run_xfer(32'h0000_4000, 8, 4, 2);
        check("fifo_flushed", dut.u_fifo.count, 0);
        run_xfer(32'h0000_5000, 4, 4, -1);
        run_xfer(32'hFFFF_FFF8, 4, 4, -1);
        run_xfer(32'h0000_6000, 20, 0, -1);
        run_xfer(32'h0000_7000, 20, 100, -1);
        run_xfer(32'h0000_8000, 0, 4, -1);
        run_xfer(32'h0000_9000, 16, 16, -1);

        build_model(32'h0000_2000, 8, 4);
        beat = 0; expect_drop = 0; err_beat = -1; widx = 0; acc_pending = 0;
        start_adr = 32'h0000_2000; buf_size = 8; burst_size = 4;
        mon_on = 1; drv_on = 1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        reached = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (beat >= 2) begin
                reached = 1;
                break;
            end
        end
        check("mid_burst_reached", reached, 1);
        check("mid_burst_cyc", wb.wb_cyc_o, 1);
        mon_on = 0; drv_on = 0; stream_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        wb.wb_ack_i = 1'b0;
        wb.wb_err_i = 1'b0;
        check("midrst_cyc_stb", {wb.wb_cyc_o, wb.wb_stb_o}, 0);
        check("midrst_busy", busy, 0);
        check("midrst_tx_cnt", tx_cnt, 0);
        check("midrst_ready", stream_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_xfer(32'h0000_3000, 6, 4, -1);

        for (int k = 0; k < 5; k++) begin
            run_xfer($urandom & 32'hFFFF_FFFC, $urandom_range(0, 24), $urandom_range(0, 20), -1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wb_stream_writer.md
WB_STREAM_WRITER -- requirements
Module: wb_stream_writer

Interface
REQ-001 SHALL have parameter WB_AW, default 32, Wishbone address width.
REQ-002 SHALL have parameter WB_DW, default 32, Wishbone and stream data width.
REQ-003 SHALL have parameter FIFO_AW, default 4, log2 of the internal FIFO depth (16 words).
REQ-004 SHALL use one clock and a synchronous, active-low reset; ports: wb_clk_i input 1, the clock; wb_rst_ni input 1, synchronous active-low reset.
REQ-005 SHALL have ports: enable input 1 start request; start_adr input WB_AW byte address; buf_size input WB_AW words to write; burst_size input WB_AW words per burst.
REQ-006 SHALL have ports: busy output 1 transfer active; tx_cnt output WB_DW words acknowledged; err output 1 sticky bus error.
REQ-007 SHALL have ports: stream_data input WB_DW; stream_valid input 1; stream_ready output 1.
REQ-008 SHALL have Wishbone master ports: wb_adr_o WB_AW, wb_dat_o WB_DW, wb_sel_o WB_DW/8, wb_we_o 1, wb_cyc_o 1, wb_stb_o 1, wb_cti_o 3, wb_bte_o 2, all outputs; wb_ack_i 1 and wb_err_i 1, inputs.

Function
REQ-009 SHALL implement states IDLE, FILL, BURST, DONE.
REQ-010 SHALL, in IDLE, on a rising edge of enable (enable high, previous cycle low), latch start_adr, buf_size and burst_size, clear tx_cnt and err, and enter FILL; busy SHALL be high from the next cycle.
REQ-011 SHALL treat latched burst_size 0 as 1 and values above 2**FIFO_AW as 2**FIFO_AW.
REQ-012 SHALL drive stream_ready = busy AND FIFO not full AND words accepted < latched buf_size; a word is accepted when stream_valid and stream_ready are both high.
REQ-013 SHALL leave FILL for BURST when FIFO count >= min(effective burst_size, buf_size - tx_cnt).
REQ-014 SHALL, in BURST, hold wb_cyc_o=wb_stb_o=wb_we_o=1, wb_sel_o all ones, wb_bte_o=00, wb_dat_o=FIFO head.
REQ-015 SHALL drive wb_cti_o=010 on every beat except the last beat of a burst, which SHALL be 111; a single-beat burst SHALL use 111.
REQ-016 SHALL, on each wb_ack_i, pop the FIFO, increment wb_adr_o by 4 and increment tx_cnt by 1.
REQ-017 SHALL drop wb_cyc_o and wb_stb_o the cycle after the last beat's ack; it then enters FILL if tx_cnt < buf_size, otherwise DONE.
REQ-018 SHALL let wb_adr_o wrap modulo 2**WB_AW without error.
REQ-019 SHALL, on wb_err_i during BURST, set err, drop cyc/stb the next cycle, flush the FIFO and enter DONE; the errored beat SHALL NOT count in tx_cnt.
REQ-020 SHALL, in DONE, deassert busy and return to IDLE after one cycle; tx_cnt and err SHALL hold until the next start.
REQ-021 SHALL, with latched buf_size 0, go FILL -> DONE in one cycle with no bus cycle.
REQ-022 SHALL ignore enable edges while busy.
REQ-023 SHALL let the FIFO push and pop in the same cycle, with the count unchanged.

Reset
REQ-024 SHALL, on wb_rst_ni low at a clock edge, enter IDLE and flush the FIFO, with outputs busy=0, err=0, tx_cnt=0, stream_ready=0, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_sel_o=0, wb_cti_o=000, wb_bte_o=00.
REQ-025 SHALL, on reset asserted mid-burst, drop wb_cyc_o at that edge and discard all transfer state.

Structure
REQ-026 SHALL place the state encoding and CTI constants (CLASSIC 000, INC 010, EOB 111) in a shared package wb_stream_pkg.
REQ-027 SHALL implement buffering as one sub-module, wb_stream_fifo: synchronous, first-word-fall-through, depth 2**FIFO_AW, with full, empty and count outputs.

Verification
REQ-028 SHALL test: start_adr=0x1000, buf_size=8, burst_size=4, stream always valid -> two 4-beat bursts; addresses 0x1000..0x101C; cti 010,010,010,111 each; tx_cnt=8; busy falls.
REQ-029 SHALL test: buf_size=5, burst_size=4 -> bursts of 4 and 1 beats; the 1-beat burst has cti=111; tx_cnt=5.
REQ-030 SHALL test: wb_err_i on beat 3 of the first burst (buf_size=8) -> err=1, tx_cnt=2, cyc low the next cycle, FIFO empty, busy low.
REQ-031 SHALL test: start_adr=0xFFFFFFF8, buf_size=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-032 SHALL test: burst_size=0 and burst_size=100 with buf_size=20 -> twenty 1-beat bursts; separately one 16-beat burst then one 4-beat burst.
REQ-033 SHALL test: wb_rst_ni low mid-burst -> cyc/stb low after that edge; after release, a new enable edge runs a clean transfer with tx_cnt starting at 0.
